// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with HI/LO result registers.
//   MULT/MULTU use shift-add, DIV/DIVU use restoring shift-subtract, one
//   step per clock. Signed ops run on magnitudes; signs are fixed in FIX.
//   Optional build macro MULDIV_EARLY_EXIT_EN: multiplies leave RUN as soon
//   as the remaining multiplier bits are all zero (results unchanged).
module muldiv_unit #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [1:0]   op,
   input  logic [N-1:0] srcA,
   input  logic [N-1:0] srcB,
   input  logic         hi_we,
   input  logic         lo_we,
   input  logic [N-1:0] wd,
   output logic         busy,
   output logic         done,
   output logic         div_zero,
   output logic [N-1:0] hi,
   output logic [N-1:0] lo
);

   localparam int CW = $clog2(N);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   logic [1:0]     state;
   logic [CW-1:0]  count;
   logic           div_q;      // latched op is a divide
   logic           neg_q;      // product / quotient must be negated
   logic           rem_neg_q;  // remainder takes the dividend's sign
   logic           dz_q;       // divisor was zero
   logic [2*N-1:0] acc;        // mul: product; div: {remainder, quotient}
   logic [2*N-1:0] b_reg;      // mul: shifted multiplicand; div: divisor in low half
   logic [N-1:0]   c_reg;      // mul: remaining multiplier bits

   // operand preparation in the launch cycle
   logic           is_signed;
   logic           a_neg;
   logic           b_neg;
   logic [N-1:0]   abs_a;
   logic [N-1:0]   abs_b;
   logic           accept;

   assign is_signed = ~op[0];
   assign a_neg     = is_signed & srcA[N-1];
   assign b_neg     = is_signed & srcB[N-1];
   assign abs_a     = a_neg ? -srcA : srcA;
   assign abs_b     = b_neg ? -srcB : srcB;
   assign accept    = (state == S_IDLE) && start;
   assign busy      = (state != S_IDLE);

   // restoring-division trial subtract: {remainder, next dividend bit} - divisor
   logic [N:0] partial;
   logic [N:0] diff;
   assign partial = acc[2*N-1:N-1];
   assign diff    = partial - {1'b0, b_reg[N-1:0]};

   // RUN termination
   logic last_step;
   logic mul_exit;
   logic run_done;
   assign last_step = (count == CW'(N - 1));
`ifdef MULDIV_EARLY_EXIT_EN
   assign mul_exit  = ~div_q & ~|c_reg[N-1:1];
`else
   assign mul_exit  = 1'b0;
`endif
   assign run_done  = last_step | mul_exit;

   // sign correction of the finished result
   logic [2*N-1:0] prod_fix;
   logic [N-1:0]   quo_fix;
   logic [N-1:0]   rem_fix;
   logic [N-1:0]   res_hi;
   logic [N-1:0]   res_lo;

   // select sign-corrected HI/LO values for the FIX write
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      prod_fix = acc;
      quo_fix  = acc[N-1:0];
      rem_fix  = acc[2*N-1:N];
      if (neg_q) begin
         prod_fix = -acc;
         quo_fix  = -acc[N-1:0];
      end
      if (rem_neg_q)
         rem_fix = -acc[2*N-1:N];
      if (dz_q)
         quo_fix = '1;
      res_hi = div_q ? rem_fix : prod_fix[2*N-1:N];
      res_lo = div_q ? quo_fix : prod_fix[N-1:0];
   end

   // control FSM: IDLE -> RUN -> FIX -> IDLE, done pulses after FIX
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         count <= '0;
         done  <= 1'b0;
      end else begin
         // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
         done <= (state == S_FIX);
         case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_RUN;
                  count <= '0;
               end
            end
            S_RUN: begin
               count <= count + CW'(1);
               if (run_done)
                  state <= S_FIX;
            end
            S_FIX:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // datapath: latch operands at launch, then one shift step per RUN cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the datapath is flops, not a memory array, so clearing it on reset is cheap and keeps state deterministic.
         div_q     <= 1'b0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         dz_q      <= 1'b0;
         acc       <= '0;
         b_reg     <= '0;
         c_reg     <= '0;
      end else if (accept) begin
         div_q     <= op[1];
         neg_q     <= a_neg ^ b_neg;
         rem_neg_q <= a_neg;
         dz_q      <= op[1] & (srcB == '0);
         acc       <= op[1] ? {{N{1'b0}}, abs_a} : '0;
         b_reg     <= op[1] ? {{N{1'b0}}, abs_b} : {{N{1'b0}}, abs_a};
         c_reg     <= abs_b;
      end else if (state == S_RUN) begin
         if (div_q) begin
            acc <= diff[N] ? {acc[2*N-2:0], 1'b0}
                           : {diff[N-1:0], acc[N-2:0], 1'b1};
         end else begin
            if (c_reg[0])
               acc <= acc + b_reg;
            b_reg <= {b_reg[2*N-2:0], 1'b0};
            c_reg <= {1'b0, c_reg[N-1:1]};
         end
      end
   end

   // architectural HI/LO and div_zero flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi       <= '0;
         lo       <= '0;
         div_zero <= 1'b0;
      end else if (state == S_FIX) begin
         hi       <= res_hi;
         lo       <= res_lo;
         div_zero <= dz_q;
      end else if (accept) begin
         // a launch takes priority over a same-cycle MTHI/MTLO
         div_zero <= 1'b0;
      end else if (state == S_IDLE) begin
         if (hi_we)
            hi <= wd;
         if (lo_we)
            lo <= wd;
      end
   end

endmodule
